// File: rtl/conv_1_collector.sv
// conv_1_collector
//   Receiving end of the first-layer convolution window stream. Each accepted
//   3x3 window is multiplied by the kernel selected by dir, summed, passed
//   through ReLU, shifted right by SHIFT and clamped to 255. The resulting byte
//   lands in mem[dir][dir_counter]. out_valid rises once the frame is complete
//   and the pipeline has drained.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low
//   win_valid    window/tags valid this cycle
//   window       3x3 unsigned pixels [row][col]
//   dir          kernel / output-map select (3 is illegal)
//   dir_counter  output position, [5:3] row, [2:0] column
//   data_done    one-cycle pulse after the last window
//   kernels      signed weights [dir][row][col]
//   out_ack      consumer done reading; releases the buffer
//   rd_map       read-port map select (3 reads as 0)
//   rd_addr      read-port position
//   rd_data      registered read data, 1-cycle latency
//   out_valid    all maps complete and readable
//   err          sticky frame error
//
// state   | meaning
// COLLECT | accepting windows until data_done
// DRAIN   | waiting for the three pipeline stages to empty
// READY   | results readable, waiting for out_ack
module conv_1_collector #(
  parameter int SHIFT = 4,
  parameter int NPOS  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          win_valid,
  input  logic [0:2][0:2][7:0]          window,
  input  logic [1:0]                    dir,
  input  logic [5:0]                    dir_counter,
  input  logic                          data_done,
  input  logic [0:2][0:2][0:2][7:0]     kernels,
  input  logic                          out_ack,
  input  logic [1:0]                    rd_map,
  input  logic [5:0]                    rd_addr,
  output logic [7:0]                    rd_data,
  output logic                          out_valid,
  output logic                          err
);

  localparam logic [7:0] FRAME_WRITES = 8'(3 * NPOS);

  typedef enum logic [1:0] {COLLECT, DRAIN, READY} state_t;
  state_t state, state_nxt;

  logic accept, stray_win, frame_short, pipe_empty, wr_en;

  // pipeline registers
  logic                 v1, v2, v3;
  logic [0:8][16:0]     prod_c, prod1;
  logic [1:0]           dir1, dir2, dir3;
  logic [5:0]           pos1, pos2, pos3;
  logic signed [20:0]   sum_c, sum2, shifted_c;
  logic [7:0]           px_c, px3;
  logic [1:0]           ksel;

  logic [7:0] wr_count;
  logic [7:0] mem [0:2][0:NPOS-1];

  function automatic logic signed [16:0] mul_px(input logic [7:0] px, input logic [7:0] wt);
    logic signed [16:0] a, b;
    a = {9'b0, px};
    b = {{9{wt[7]}}, wt};
    return a * b;
  endfunction

  function automatic logic signed [20:0] sx(input logic [16:0] p);
    return {{4{p[16]}}, p};
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nxt;
  end

  assign pipe_empty = !v1 && !v2 && !v3;

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (data_done)  state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = READY;
      READY:   if (out_ack)    state_nxt = COLLECT;
      default:                 state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    out_valid   = (state == READY);
    accept      = win_valid && (state == COLLECT);
    stray_win   = win_valid && (state != COLLECT);
    frame_short = (state == DRAIN) && pipe_empty && (wr_count != FRAME_WRITES);
  end

  // ---------------- datapath ----------------
  // dir=3 never gets written; any legal kernel may feed its products.
  assign ksel = (dir == 2'd3) ? 2'd0 : dir;

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign prod_c[r*3+c] = mul_px(window[r][c], kernels[ksel][r][c]);
    end
  end

  // nine 17b signed products cannot exceed 21b signed
  assign sum_c = sx(prod1[0]) + sx(prod1[1]) + sx(prod1[2])
               + sx(prod1[3]) + sx(prod1[4]) + sx(prod1[5])
               + sx(prod1[6]) + sx(prod1[7]) + sx(prod1[8]);

  assign shifted_c = sum2 >>> SHIFT;

  always_comb begin
    px_c = 8'd0;
    if (sum2[20])                   px_c = 8'd0;
    else if (shifted_c > 21'sd255)  px_c = 8'd255;
    else                            px_c = shifted_c[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      prod1 <= prod_c;
      dir1  <= dir;
      pos1  <= dir_counter;
    end
    sum2 <= sum_c;
    dir2 <= dir1;
    pos2 <= pos1;
    px3  <= px_c;
    dir3 <= dir2;
    pos3 <= pos2;
  end

  assign wr_en = v3 && (dir3 != 2'd3);

  always_ff @(posedge clk) begin
    if (wr_en) mem[dir3][pos3] <= px3;
  end

  always_ff @(posedge clk) begin
    if (!reset)                rd_data <= 8'd0;
    else if (rd_map == 2'd3)   rd_data <= 8'd0;
    else                       rd_data <= mem[rd_map][rd_addr];
  end

  // ---------------- bookkeeping ----------------
  always_ff @(posedge clk) begin
    if (!reset)                          wr_count <= 8'd0;
    else if (state == READY && out_ack)  wr_count <= 8'd0;
    else if (wr_en)                      wr_count <= wr_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset)                                            err <= 1'b0;
    else if (state == READY && out_ack)                    err <= 1'b0;
    else if (stray_win || frame_short || (v3 && !wr_en))   err <= 1'b1;
  end

endmodule
